decryption_pipe: RTL and testbench
==================================

Name: decryption_pipe

Overview:
- Five-stage pipelined decrypter sitting directly downstream of the encryption pipeline; consumes its `e_data` word plus the per-word key and recovers the plaintext.
- Applies the exact inverse operations in reverse order: half-swap, bit-reverse, NOT, half-swap, XOR key.
- Adds a valid/ready handshake on both sides with a global stall, a busy flag and a delivered-word counter, so it can sit in front of a backpressuring sink.

Parameters:
- N, 8: data/key width in bits; must be even and >= 2 (half-swap requires it).
- CNT_W, 16: width of the delivered-word counter.

Ports:
- clock, input, 1: single clock, all state updates on rising edge.
- reset_n, input, 1: synchronous, active-low reset, sampled on the rising edge of clock.
- in_valid, input, 1: e_data/key word presented.
- in_ready, output, 1: block accepts the word this cycle.
- e_data, input, N: encrypted word.
- key, input, N: key used to encrypt this word; travels with it through the pipe.
- out_valid, output, 1: decrypted word present on d_data.
- out_ready, input, 1: sink accepts d_data this cycle.
- d_data, output, N: decrypted word.
- busy, output, 1: any stage holds a valid word.
- out_count, output, CNT_W: number of words delivered since reset.

Behaviour:
- Reset (reset_n=0 at a rising edge):
  - All stage valid bits cleared; in-flight words are dropped, including on reset mid-operation.
  - out_valid=0, d_data=0, busy=0, out_count=0.
  - All stage data/key registers cleared to 0.
  - in_ready=1 combinationally, since the pipe is empty.
- Stages D1..D5 each hold: valid, data[N-1:0], key[N-1:0] (key is not needed after D5).
  - D1 = {e_data[N/2-1:0], e_data[N-1:N/2]} (half-swap).
  - D2[i] = D1[N-1-i] for i=0..N-1 (bit reverse).
  - D3 = ~D2.
  - D4 = half-swap of D3.
  - D5 = D4 ^ key carried with the word.
  - D5 drives d_data/out_valid.
- advance = !out_valid || out_ready. in_ready = advance (combinational).
- On each rising edge with reset_n=1 and advance=1:
  - Every stage valid shifts one stage down; D1.valid <= in_valid.
  - Each stage's data/key register loads only when its incoming valid is 1. Otherwise it holds, so d_data retains the last delivered word after the pipe drains.
- advance=0: all stages hold (global stall). The input is not accepted; in_valid/e_data/key are ignored that cycle.
- Bubbles are not collapsed: an empty stage still occupies a pipeline slot.
- Latency: a word accepted at edge t appears with out_valid=1 after edge t+4 and is visible throughout the following cycle (5 register stages, the same depth as the encrypter). Throughput: 1 word/cycle when out_ready=1.
- Transfer out occurs when out_valid && out_ready at a rising edge; out_count increments by 1 on each transfer and wraps from 2^CNT_W-1 to 0.
- Simultaneous transfer out and accept in during the same cycle is legal, and the pipe stays full.
- busy = OR of all five stage valid bits (combinational from registers).
- out_valid, once high, stays high with d_data stable until out_ready=1 (standard valid/ready; no retraction).
- Upstream holding rule: when in_ready=0, upstream must hold its word; the block makes no assumption about that.

Test Plan:
1. Single word, N=8: reset, then key=0x0F, e_data=0x47, in_valid=1 for one cycle, out_ready=1 -> out_valid=1 after the 5th edge with d_data=0x12; out_count=1; busy returns to 0.
2. Back-to-back stream with out_ready=1: e_data/key pairs (0x47/0x0F), (0x66/0x3C), (0x00/0x00) on consecutive cycles -> d_data 0x12, 0xA5, 0xFF on consecutive cycles; in_ready stays 1; out_count=3.
3. Backpressure: fill the pipe with 5 words, hold out_ready=0 for 4 cycles -> in_ready=0; d_data and out_valid frozen; no word lost or duplicated; after release the words drain in order and out_count=5.
4. Reset mid-operation: 3 words in flight, drive reset_n=0 for 1 edge -> out_valid=0, busy=0, d_data=0, out_count=0; those words never appear at the output.
5. Round trip: feed 256 random keys/data through encryption, then decryption_pipe, with random out_ready -> every d_data equals its original data, in order.
6. Counter wrap with CNT_W=4: deliver 17 words -> out_count reads 0xF after 15 words, 0x0 after 16, 0x1 after 17.

Source files
------------

// File: rtl/decryption_pipe.sv
// Five-stage decrypter undoing the encryption pipeline (half-swap, bit-reverse,
// NOT, half-swap, XOR key) behind valid/ready handshakes with a global stall.
module decryption_pipe #(
   parameter int N     = 8,
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     e_data,
   input  logic [N-1:0]     key,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N-1:0]     d_data,
   output logic             busy,
   output logic [CNT_W-1:0] out_count
);

   generate
      if ((N < 2) || ((N % 2) != 0)) begin : g_bad_width
         $error("decryption_pipe: N must be even and >= 2");
      end
   endgenerate

   function automatic logic [N-1:0] half_swap(input logic [N-1:0] x);
      return {x[N/2-1:0], x[N-1:N/2]};
   endfunction

   function automatic logic [N-1:0] bit_rev(input logic [N-1:0] x);
      logic [N-1:0] r;
      for (int i = 0; i < N; i++) begin
         r[i] = x[N-1-i];
      end
      return r;
   endfunction

   logic             r_vld_p1, r_vld_p2, r_vld_p3, r_vld_p4, r_vld_p5;
   logic [N-1:0]     r_data_p1, r_data_p2, r_data_p3, r_data_p4, r_data_p5;
   logic [N-1:0]     r_key_p1, r_key_p2, r_key_p3, r_key_p4;
   logic [CNT_W-1:0] r_count;
   logic             w_advance;
   logic             w_xfer_out;

   // The whole pipe moves together; a full output slot blocks every stage.
   assign w_advance  = !r_vld_p5 || out_ready;
   assign w_xfer_out = r_vld_p5 && out_ready;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_vld_p1  <= 1'b0;
         r_vld_p2  <= 1'b0;
         r_vld_p3  <= 1'b0;
         r_vld_p4  <= 1'b0;
         r_vld_p5  <= 1'b0;
         r_data_p1 <= '0;
         r_data_p2 <= '0;
         r_data_p3 <= '0;
         r_data_p4 <= '0;
         r_data_p5 <= '0;
         r_key_p1  <= '0;
         r_key_p2  <= '0;
         r_key_p3  <= '0;
         r_key_p4  <= '0;
         r_count   <= '0;
      end else if (w_advance) begin
         r_vld_p1 <= in_valid;
         r_vld_p2 <= r_vld_p1;
         r_vld_p3 <= r_vld_p2;
         r_vld_p4 <= r_vld_p3;
         r_vld_p5 <= r_vld_p4;
         // Stage D1: half-swap
         if (in_valid) begin
            r_data_p1 <= half_swap(e_data);
            r_key_p1  <= key;
         end
         // Stage D2: bit reverse
         if (r_vld_p1) begin
            r_data_p2 <= bit_rev(r_data_p1);
            r_key_p2  <= r_key_p1;
         end
         // Stage D3: invert
         if (r_vld_p2) begin
            r_data_p3 <= ~r_data_p2;
            r_key_p3  <= r_key_p2;
         end
         // Stage D4: half-swap
         if (r_vld_p3) begin
            r_data_p4 <= half_swap(r_data_p3);
            r_key_p4  <= r_key_p3;
         end
         // Stage D5: remove key; holds last word once the pipe drains
         if (r_vld_p4) begin
            r_data_p5 <= r_data_p4 ^ r_key_p4;
         end
         if (w_xfer_out) begin
            r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   assign in_ready  = w_advance;
   assign out_valid = r_vld_p5;
   assign d_data    = r_data_p5;
   assign busy      = r_vld_p1 | r_vld_p2 | r_vld_p3 | r_vld_p4 | r_vld_p5;
   assign out_count = r_count;

endmodule

// File: tb/tb_decryption_pipe.sv
// Directed bench for decryption_pipe: latency, streaming, backpressure,
// mid-flight reset, encrypt/decrypt round trip and counter wrap.
module tb_decryption_pipe;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        in_valid, in_ready, out_valid, out_ready, busy;
   logic [7:0]  e_data, key, d_data;
   logic [15:0] out_count;

   logic        reset4_n;
   logic        in_valid4, in_ready4, out_valid4, out_ready4, busy4;
   logic [7:0]  e_data4, key4, d_data4;
   logic [3:0]  out_count4;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   decryption_pipe #(.N(8), .CNT_W(16)) dut (
      .clock(clock), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .e_data(e_data), .key(key),
      .out_valid(out_valid), .out_ready(out_ready),
      .d_data(d_data), .busy(busy), .out_count(out_count)
   );

   decryption_pipe #(.N(8), .CNT_W(4)) dut4 (
      .clock(clock), .reset_n(reset4_n),
      .in_valid(in_valid4), .in_ready(in_ready4),
      .e_data(e_data4), .key(key4),
      .out_valid(out_valid4), .out_ready(out_ready4),
      .d_data(d_data4), .busy(busy4), .out_count(out_count4)
   );

   function automatic logic [7:0] hswap(input logic [7:0] x);
      return {x[3:0], x[7:4]};
   endfunction

   function automatic logic [7:0] brev(input logic [7:0] x);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = x[7-i];
      return r;
   endfunction

   // Forward encryption: XOR key, half-swap, NOT, bit-reverse, half-swap.
   function automatic logic [7:0] encrypt(input logic [7:0] d, input logic [7:0] k);
      logic [7:0] t;
      t = d ^ k;
      t = hswap(t);
      t = ~t;
      t = brev(t);
      return hswap(t);
   endfunction

   task automatic apply_reset();
      @(negedge clock);
      reset_n  = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; in_valid = 1'b0; e_data = '0; key = '0; out_ready = 1'b1;
      repeat (2) @(negedge clock);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
      n_checks++; if (d_data !== 8'h00) begin n_fail++; $display("FAIL reset_d_data got=%h exp=00", d_data); end
      n_checks++; if (out_count !== 16'd0) begin n_fail++; $display("FAIL reset_out_count got=%0d exp=0", out_count); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      reset_n = 1'b1;
   endtask

   task automatic test_single();
      @(negedge clock);
      in_valid = 1'b1; e_data = 8'h47; key = 8'h0F; out_ready = 1'b1;
      @(negedge clock);
      in_valid = 1'b0;
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got=%b exp=1", busy); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid cyc=%0d got=%b exp=0", i, out_valid); end
      end
      @(negedge clock);
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got=%b exp=1", out_valid); end
      n_checks++; if (d_data !== 8'h12) begin n_fail++; $display("FAIL single_data got=%h exp=12", d_data); end
      @(negedge clock);
      n_checks++; if (out_count !== 16'd1) begin n_fail++; $display("FAIL single_count got=%0d exp=1", out_count); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end got=%b exp=0", busy); end
      n_checks++; if (d_data !== 8'h12) begin n_fail++; $display("FAIL single_data_held got=%h exp=12", d_data); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] ev [3] = '{8'h47, 8'h66, 8'h00};
      logic [7:0] kv [3] = '{8'h0F, 8'h3C, 8'h00};
      logic [7:0] dv [3] = '{8'h12, 8'hA5, 8'hFF};
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready i=%0d got=%b exp=1", i, in_ready); end
         in_valid = 1'b1; e_data = ev[i]; key = kv[i];
      end
      @(negedge clock);
      in_valid = 1'b0;
      @(negedge clock);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_early_valid got=%b exp=0", out_valid); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         n_checks++; if (out_valid !== 1'b1 || d_data !== dv[i]) begin n_fail++; $display("FAIL b2b_out i=%0d got=%b/%h exp=1/%h", i, out_valid, d_data, dv[i]); end
      end
      @(negedge clock);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drained got=%b exp=0", out_valid); end
      n_checks++; if (out_count !== 16'd3) begin n_fail++; $display("FAIL b2b_count got=%0d exp=3", out_count); end
   endtask

   task automatic test_backpressure();
      logic [7:0] pv [5] = '{8'h3A, 8'hC5, 8'h01, 8'h80, 8'h7E};
      logic [7:0] kv [5] = '{8'h11, 8'hF0, 8'h99, 8'h00, 8'h5A};
      apply_reset();
      @(negedge clock);
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; e_data = encrypt(pv[i], kv[i]); key = kv[i];
         @(negedge clock);
      end
      // Junk word offered while stalled must be ignored.
      e_data = 8'hAA; key = 8'h55; in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready i=%0d got=%b exp=0", i, in_ready); end
         n_checks++; if (out_valid !== 1'b1 || d_data !== pv[0]) begin n_fail++; $display("FAIL bp_frozen i=%0d got=%b/%h exp=1/%h", i, out_valid, d_data, pv[0]); end
         @(negedge clock);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
      for (int i = 0; i < 5; i++) begin
         n_checks++; if (out_valid !== 1'b1 || d_data !== pv[i]) begin n_fail++; $display("FAIL bp_drain i=%0d got=%b/%h exp=1/%h", i, out_valid, d_data, pv[i]); end
         @(negedge clock);
      end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_extra_word got=%b exp=0", out_valid); end
      n_checks++; if (out_count !== 16'd5) begin n_fail++; $display("FAIL bp_count got=%0d exp=5", out_count); end
   endtask

   task automatic test_reset_mid();
      int seen = 0;
      @(negedge clock);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; e_data = 8'h10 + 8'(i); key = 8'h33;
         @(negedge clock);
      end
      in_valid = 1'b0; reset_n = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid got=%b exp=0", out_valid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy got=%b exp=0", busy); end
      n_checks++; if (d_data !== 8'h00) begin n_fail++; $display("FAIL mid_d_data got=%h exp=00", d_data); end
      n_checks++; if (out_count !== 16'd0) begin n_fail++; $display("FAIL mid_count got=%0d exp=0", out_count); end
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         if (out_valid === 1'b1) seen++;
      end
      n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL mid_ghost_words got=%0d exp=0", seen); end
   endtask

   task automatic test_round_trip();
      logic [7:0] pv [256];
      logic [7:0] kv [256];
      int wr = 0, rd = 0, cyc = 0;
      for (int i = 0; i < 256; i++) begin
         pv[i] = 8'($urandom); kv[i] = 8'($urandom);
      end
      apply_reset();
      while (rd < 256 && cyc < 5000) begin
         @(negedge clock);
         cyc++;
         out_ready = ($urandom_range(0, 3) != 0);
         in_valid  = (wr < 256) && ($urandom_range(0, 4) != 0);
         e_data    = (wr < 256) ? encrypt(pv[wr], kv[wr]) : 8'h00;
         key       = (wr < 256) ? kv[wr] : 8'h00;
         #1;
         if (out_valid && out_ready) begin
            n_checks++; if (d_data !== pv[rd]) begin n_fail++; $display("FAIL rt_word idx=%0d got=%h exp=%h", rd, d_data, pv[rd]); end
            rd++;
         end
         if (in_valid && in_ready) wr++;
      end
      n_checks++; if (rd !== 256) begin n_fail++; $display("FAIL rt_timeout got=%0d exp=256 words", rd); end
      @(negedge clock);
      in_valid = 1'b0; out_ready = 1'b1;
   endtask

   task automatic test_count_wrap();
      reset4_n = 1'b0; in_valid4 = 1'b0; e_data4 = '0; key4 = '0; out_ready4 = 1'b1;
      repeat (2) @(negedge clock);
      reset4_n = 1'b1;
      for (int j = 0; j < 23; j++) begin
         @(negedge clock);
         if (j == 6) begin
            n_checks++; if (out_count4 !== 4'h1 || d_data4 !== 8'hFF) begin n_fail++; $display("FAIL wrap_first got=%h/%h exp=1/ff", out_count4, d_data4); end
         end
         if (j == 20) begin
            n_checks++; if (out_count4 !== 4'hF) begin n_fail++; $display("FAIL wrap_15 got=%h exp=f", out_count4); end
         end
         if (j == 21) begin
            n_checks++; if (out_count4 !== 4'h0) begin n_fail++; $display("FAIL wrap_16 got=%h exp=0", out_count4); end
         end
         if (j == 22) begin
            n_checks++; if (out_count4 !== 4'h1) begin n_fail++; $display("FAIL wrap_17 got=%h exp=1", out_count4); end
         end
         in_valid4 = (j < 17);
         e_data4   = encrypt(8'hFF, 8'h00);
         key4      = 8'h00;
      end
   endtask

   initial begin
      reset4_n = 1'b0; in_valid4 = 1'b0; e_data4 = '0; key4 = '0; out_ready4 = 1'b1;
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      test_round_trip();
      test_count_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired before summary");
      $fatal(1, "watchdog");
   end

endmodule
